pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the picoMIPS fetch path. Holds the current instruction address and drives it combinationally into the program memory address port; the memory returns the instruction in the same cycle for the decoder. Each clock it advances, branches or stalls according to decoder controls, and supports a wait-for-switch instruction (press-and-release handshake on an asynchronous input) and a terminal halt.

## Interface

Parameters:
- Psize, 4: PC and program-memory address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  out  Psize  current PC; drives program memory address.
- pc_ctrl  in  2  next-PC select from decoder: 00 increment, 01 conditional relative branch, 10 absolute jump, 11 hold.
- cond  in  1  branch condition (e.g. ALU zero flag); qualifies pc_ctrl=01 only.
- target  in  Psize  offset (pc_ctrl=01, two's complement) or absolute address (pc_ctrl=10).
- wait_op  in  1  current instruction is a wait-for-switch.
- halt_op  in  1  current instruction is halt.
- ready_in  in  1  asynchronous external switch; not synchronous to clk.
- stalled  out  1  high while in a wait state.
- halted  out  1  high while in HALT.
- retire  out  1  one-cycle pulse after each edge at which an instruction completed.

## Operation

- ready_in passes through a 2-flop synchroniser (reset 0); only the synchronised value ready_s is used.
- States: RUN, WAIT_PRESS, WAIT_RELEASE, HALT. Reset state RUN.
- RUN, priority halt_op > wait_op > pc_ctrl:
  - halt_op=1: PC unchanged, next state HALT, no retire.
  - wait_op=1: PC unchanged, next state WAIT_PRESS, no retire.
  - otherwise PC_next per pc_ctrl; retire set:
    - 00: PC+1.
    - 01: cond=1 -> PC + target (signed); cond=0 -> PC+1.
    - 10: target.
    - 11: PC (self-loop; counts as retired).
- WAIT_PRESS: PC held, pc_ctrl/wait_op/halt_op ignored; ready_s=1 -> WAIT_RELEASE.
- WAIT_RELEASE: PC held; ready_s=0 -> RUN with PC+1 and retire set.
- HALT: PC, state frozen; only reset exits.
- Arithmetic modulo 2^Psize: PC+1 from all-ones wraps to 0; relative branch sums wrap both directions, carry discarded.

## Timing

- Reset (asynchronous, immediate): address=0, state RUN, stalled=0, halted=0, retire=0, synchroniser flops 0.
- address is a register output; PC updates one edge after controls are sampled. Single-cycle fetch: one instruction per cycle in RUN.
- stalled = state is WAIT_PRESS or WAIT_RELEASE; halted = state is HALT; both state decodes, glitch-free, asserted from the edge entering the state.
- retire registered: high for exactly the cycle following a completing edge; 0 otherwise, including during stall and halt.
- ready_in latency: a level change is visible at ready_s after 2 edges; WAIT_PRESS exits on the edge where ready_s first reads 1. Minimum wait duration: 1 cycle in WAIT_PRESS + 1 in WAIT_RELEASE when the switch pulse straddles the edges.
- If ready_s is already 1 when entering WAIT_PRESS, exit to WAIT_RELEASE on the next edge (level-sensitive, not edge-detected); the release phase still enforces a full handshake.
- Reset asserted mid-wait or mid-halt: immediate return to PC=0, RUN; the pending handshake is discarded.

## Test plan

- Reset then pc_ctrl=00 for 18 cycles -> address 0,1,…,15,0,1; retire high each cycle from cycle 2.
- PC=5, pc_ctrl=01, target=4'b1101 (-3), cond=1 -> PC=2; same with cond=0 -> PC=6; PC=14, target=3, cond=1 -> PC=1 (wrap).
- PC=3, pc_ctrl=10, target=9 -> PC=9 next edge; pc_ctrl=11 -> PC stays 9, retire still pulses.
- PC=7, wait_op=1 -> stalled=1, PC=7; raise ready_in for 5 cycles then drop -> stalled falls and PC=8 only after release, retire pulses once; ready_in already high at entry -> still requires release before PC=8.
- PC=4, halt_op=1 and wait_op=1 together -> halted=1, stalled=0, PC=4 frozen for 20 cycles regardless of inputs; reset pulse -> PC=0, halted=0.
- Assert reset asynchronously (between edges) while in WAIT_RELEASE at PC=10 -> address=0, stalled=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the picoMIPS fetch path: increment, relative branch,
// absolute jump and hold, plus a wait-for-switch handshake and a terminal halt.
module pc_sequencer #(
  parameter int Psize = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [Psize-1:0] address,
  input  logic [1:0]       pc_ctrl,
  input  logic             cond,
  input  logic [Psize-1:0] target,
  input  logic             wait_op,
  input  logic             halt_op,
  input  logic             ready_in,
  output logic             stalled,
  output logic             halted,
  output logic             retire
);

  // Encoding keeps stalled and halted as direct flop bits so the status
  // outputs never glitch when the state changes: {release_phase, stalled, halted}.
  typedef enum logic [2:0] {
    RUN          = 3'b000,
    WAIT_PRESS   = 3'b010,
    WAIT_RELEASE = 3'b110,
    HALT         = 3'b001
  } state_e;

  typedef enum logic [1:0] {
    PC_INC  = 2'b00,
    PC_BRA  = 2'b01,
    PC_JMP  = 2'b10,
    PC_HOLD = 2'b11
  } pc_ctrl_e;

  state_e           state_q, state_d;
  logic [Psize-1:0] pc_q, pc_d;
  logic [Psize-1:0] pc_inc;
  logic             retire_q, retire_d;
  logic             ready_meta_q, ready_s_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_meta_q <= 1'b0;
      ready_s_q    <= 1'b0;
    end else begin
      ready_meta_q <= ready_in;
      ready_s_q    <= ready_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= '0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      retire_q <= retire_d;
    end
  end

  // Addition is modulo 2^Psize, so a two's-complement offset needs no sign handling.
  assign pc_inc = pc_q + {{(Psize-1){1'b0}}, 1'b1};

  // NOTE: every output of this block gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    retire_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (halt_op) begin
          state_d = HALT;
        end else if (wait_op) begin
          state_d = WAIT_PRESS;
        end else begin
          retire_d = 1'b1;
          unique case (pc_ctrl_e'(pc_ctrl))
            PC_INC:  pc_d = pc_inc;
            PC_BRA:  pc_d = cond ? (pc_q + target) : pc_inc;
            PC_JMP:  pc_d = target;
            PC_HOLD: pc_d = pc_q;
            default: pc_d = pc_q;
          endcase
        end
      end
      WAIT_PRESS: begin
        if (ready_s_q) state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!ready_s_q) begin
          state_d  = RUN;
          pc_d     = pc_inc;
          retire_d = 1'b1;
        end
      end
      HALT: ;
      default: state_d = RUN;
    endcase
  end

  assign address = pc_q;
  assign stalled = state_q[1];
  assign halted  = state_q[0];
  assign retire  = retire_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the sequencer's rules.
module tb_pc_sequencer;

  localparam int Psize = 4;
  localparam int MOD   = 1 << Psize;

  localparam int M_RUN = 0, M_PRESS = 1, M_RELEASE = 2, M_HALT = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [Psize-1:0] address;
  logic [1:0]       pc_ctrl = 2'b00;
  logic             cond = 1'b0;
  logic [Psize-1:0] target = '0;
  logic             wait_op = 1'b0;
  logic             halt_op = 1'b0;
  logic             ready_in = 1'b0;
  logic             stalled, halted, retire;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_pc, m_mode, m_retire;
  bit m_s1, m_s2;

  pc_sequencer #(.Psize(Psize)) dut (
    .clk(clk), .reset(reset), .address(address), .pc_ctrl(pc_ctrl), .cond(cond),
    .target(target), .wait_op(wait_op), .halt_op(halt_op), .ready_in(ready_in),
    .stalled(stalled), .halted(halted), .retire(retire)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0; m_mode = M_RUN; m_retire = 0; m_s1 = 0; m_s2 = 0;
  endfunction

  // One clock edge of the sequencer, evaluated from the rules with integer arithmetic.
  function automatic void model_step();
    bit rs;
    int off;
    rs   = m_s2;
    m_s2 = m_s1;
    m_s1 = ready_in;
    m_retire = 0;
    case (m_mode)
      M_RUN: begin
        if (halt_op)      m_mode = M_HALT;
        else if (wait_op) m_mode = M_PRESS;
        else begin
          m_retire = 1;
          case (pc_ctrl)
            2'd0: m_pc = (m_pc + 1) % MOD;
            2'd1: begin
              off  = (int'(target) >= MOD / 2) ? int'(target) - MOD : int'(target);
              m_pc = cond ? (m_pc + off + MOD) % MOD : (m_pc + 1) % MOD;
            end
            2'd2: m_pc = int'(target);
            default: ;
          endcase
        end
      end
      M_PRESS:   if (rs) m_mode = M_RELEASE;
      M_RELEASE: if (!rs) begin m_mode = M_RUN; m_pc = (m_pc + 1) % MOD; m_retire = 1; end
      default: ;
    endcase
  endfunction

  task automatic compare();
    check("address", int'(address), m_pc);
    check("stalled", int'(stalled), int'(m_mode == M_PRESS || m_mode == M_RELEASE));
    check("halted",  int'(halted),  int'(m_mode == M_HALT));
    check("retire",  int'(retire),  m_retire);
  endtask

  // Advance one cycle; inputs are changed only after this returns (at the falling edge).
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic go_to(input int v);
    halt_op = 0; wait_op = 0; pc_ctrl = 2'd2; target = Psize'(v);
    tick();
    check("goto", int'(address), v);
    pc_ctrl = 2'd0;
  endtask

  task automatic wait_release(input string tag);
    int n = 0;
    while (stalled && n < 20) begin tick(); n++; end
    check(tag, int'(stalled), 0);
  endtask

  initial begin
    model_reset();
    #1;
    compare();
    tick();
    tick();
    reset = 1'b0;

    // Increment run with wrap.
    for (int i = 0; i < 18; i++) tick();
    check("inc_wrap", int'(address), 2);

    // Relative branches.
    go_to(5);
    pc_ctrl = 2'd1; target = 4'b1101; cond = 1; tick();
    check("bra_back", int'(address), 2);
    go_to(5);
    pc_ctrl = 2'd1; target = 4'b1101; cond = 0; tick();
    check("bra_not_taken", int'(address), 6);
    go_to(14);
    pc_ctrl = 2'd1; target = 4'd3; cond = 1; tick();
    check("bra_wrap", int'(address), 1);

    // Jump then hold.
    go_to(3);
    pc_ctrl = 2'd2; target = 4'd9; tick();
    check("jump", int'(address), 9);
    pc_ctrl = 2'd3; tick();
    check("hold_pc", int'(address), 9);
    check("hold_retire", int'(retire), 1);

    // Wait handshake with a 5-cycle switch pulse.
    go_to(7);
    wait_op = 1; tick();
    check("wait_stalled", int'(stalled), 1);
    check("wait_pc", int'(address), 7);
    wait_op = 0; pc_ctrl = 2'd2; target = 4'd12; halt_op = 1;
    ready_in = 1;
    for (int i = 0; i < 5; i++) tick();
    check("wait_still_stalled", int'(stalled), 1);
    halt_op = 0;
    ready_in = 0;
    wait_release("wait_exit");
    check("wait_done_pc", int'(address), 8);
    check("wait_done_retire", int'(retire), 1);

    // Switch already pressed on entry: release still required.
    ready_in = 1; pc_ctrl = 2'd3;
    tick(); tick(); tick();
    wait_op = 1; tick();
    wait_op = 0;
    for (int i = 0; i < 6; i++) tick();
    check("preheld_stalled", int'(stalled), 1);
    check("preheld_pc", int'(address), 8);
    ready_in = 0;
    wait_release("preheld_exit");
    check("preheld_done_pc", int'(address), 9);
    pc_ctrl = 2'd0;

    // Halt has priority over wait and freezes everything.
    go_to(4);
    halt_op = 1; wait_op = 1; tick();
    check("halt_flag", int'(halted), 1);
    check("halt_not_stalled", int'(stalled), 0);
    for (int i = 0; i < 20; i++) begin
      pc_ctrl = 2'($urandom); cond = 1'($urandom); target = Psize'($urandom);
      wait_op = 1'($urandom); halt_op = 1'($urandom); ready_in = 1'($urandom);
      tick();
    end
    check("halt_frozen_pc", int'(address), 4);
    reset = 1; #1;
    model_reset();
    check("halt_reset_pc", int'(address), 0);
    check("halt_reset_flag", int'(halted), 0);
    halt_op = 0; wait_op = 0; ready_in = 0; pc_ctrl = 2'd0;
    tick();
    reset = 0;

    // Asynchronous reset while waiting for release at PC=10.
    go_to(10);
    wait_op = 1; tick();
    wait_op = 0; ready_in = 1;
    tick(); tick(); tick();
    check("async_in_release", int'(stalled), 1);
    #2 reset = 1;
    #1;
    model_reset();
    check("async_reset_pc", int'(address), 0);
    check("async_reset_stalled", int'(stalled), 0);
    ready_in = 0;
    tick();
    reset = 0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      pc_ctrl = 2'($urandom);
      cond    = 1'($urandom);
      target  = Psize'($urandom);
      wait_op = ($urandom_range(0, 7) == 0);
      halt_op = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) ready_in = ~ready_in;
      if (m_mode == M_HALT && $urandom_range(0, 5) == 0) begin
        reset = 1; tick(); reset = 0;
      end else if ($urandom_range(0, 199) == 0) begin
        #3 reset = 1; #1;
        model_reset();
        compare();
        tick();
        reset = 0;
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
